periph_bus_arbiter: RTL and testbench
=====================================

Name: periph_bus_arbiter

Overview:
- Shares the single memory-mapped peripheral bus (address / data / read / write strobes, as decoded by the GPIO and other peripherals at 0x1000_0000 and up) between two requesters.
- Requester 0 is the CPU load/store unit; requester 1 is the debug/DMA port.
- Round-robin arbitration with a registered 3-state access sequencer.
- Every granted transaction drives exactly one single-cycle read or write strobe on the bus and returns a one-cycle ack to the owner.

Parameters:
- ADDR_W, 64, address width of requesters and bus.
- DATA_W, 64, data width of requesters and bus.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0, req1  input  1 each  access request; held high until matching ack.
- we0, we1  input  1 each  1 = write, 0 = read; stable while req high.
- addr0, addr1  input  ADDR_W each  target address; stable while req high.
- wdata0, wdata1  input  DATA_W each  write data; stable while req high.
- gnt0, gnt1  output  1 each  requester owns bus (ACCESS and RESP states).
- ack0, ack1  output  1 each  one-cycle completion pulse.
- rdata  output  DATA_W  read data; valid in the ack cycle.
- bus_address  output  ADDR_W  address to peripherals.
- bus_wdata  output  DATA_W  write data to peripherals.
- bus_rdata  input  DATA_W  read data from peripherals (combinational response).
- bus_read, bus_write  output  1 each  single-cycle strobes.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async): state = IDLE; all gnt/ack/bus_read/bus_write/busy = 0; bus_address, bus_wdata, rdata = 0; priority pointer = 0 (requester 0 preferred first).
- IDLE:
  - No req: stay IDLE; outputs 0.
  - Exactly one req: select it.
  - Both req: select the requester indicated by the pointer.
  - On selection: register owner, addr, wdata, we; go to ACCESS next cycle.
- ACCESS (1 cycle):
  - gnt[owner] = 1; bus_address / bus_wdata driven from registers.
  - bus_write = we, bus_read = !we.
  - Reads: bus_rdata captured into rdata at the end of this cycle.
  - Go to RESP.
- RESP (1 cycle):
  - gnt[owner] = 1, ack[owner] = 1; bus strobes 0.
  - rdata holds the captured value (for writes, rdata is unchanged).
  - Pointer = other requester; go to IDLE.
- Latency: req sampled high at edge N -> ACCESS strobes during cycle N+1 -> ack during cycle N+2 -> IDLE at N+3. Minimum per-access period is 3 cycles.
- Continuous requests from both requesters alternate 0,1,0,1...
- A single requester holding req continuously is served every 3 cycles.
- Req deasserted while owner is in ACCESS/RESP: transaction completes and ack is still pulsed (protocol violation, no abort).
- Non-owner req arriving during ACCESS/RESP: waits; it is considered in the next IDLE cycle.
- Strobes are never asserted in IDLE or RESP; bus_read and bus_write are never high together.
- Reset mid-transaction: immediate return to IDLE, no ack, strobes drop asynchronously.
- rdata holds its last value between acks.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: adds inputs lock0 and lock1 (1 bit each). If lock[owner] = 1 in the RESP cycle, the pointer is not advanced. The owner keeps priority in the next IDLE arbitration even if the other req is high, so read-modify-write sequences on GPIO direction/port registers are atomic.
  - Lock is honoured for at most 4 consecutive transactions. After the 4th, the pointer advances regardless (starvation guard, 3-bit counter cleared on unlocked RESP or reset).
- Not defined: no lock ports, pure round-robin.

Test Plan:
- Reset -> all outputs 0, busy = 0. req0 write addr 0x1000_0008 wdata 0xFF -> bus_write high exactly 1 cycle with bus_address 0x1000_0008 and bus_wdata 0xFF; ack0 two cycles after req sampled.
- req1 read 0x1000_0000 with bus_rdata = 0xA5A5 -> bus_read for 1 cycle; rdata = 0xA5A5 in the ack1 cycle and held afterwards.
- req0 and req1 both high continuously -> grant order 0,1,0,1; ack every 3 cycles; each gnt lasts 2 cycles; no overlap of gnt0/gnt1.
- req1 raised during a requester-0 ACCESS -> requester 1 served next; bus strobes never overlap.
- Reset asserted during ACCESS -> strobes and gnt drop immediately; no ack; the first post-reset arbitration with both req high grants requester 0.
- ARB_LOCK_EN: lock0 = 1 with both req high -> four consecutive requester-0 grants, then requester 1 is granted.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between the CPU LSU (requester 0)
// and the debug/DMA port (requester 1). Define ARB_LOCK_EN to add lock0/lock1.
module periph_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_read,
    output logic              bus_write,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_nx;
    logic                owner, ptr, ptr_nx, sel;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;

`ifdef ARB_LOCK_EN
    logic       lock_own, lock_hold;
    logic [2:0] lock_cnt;

    // A locked owner keeps priority, but only for 4 transactions in a row.
    assign lock_own  = owner ? lock1 : lock0;
    assign lock_hold = lock_own && (lock_cnt < 3'd3);
    assign ptr_nx    = lock_hold ? owner : !owner;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lock_cnt <= 3'd0;
        else if (state == RESP)
            lock_cnt <= lock_hold ? lock_cnt + 3'd1 : 3'd0;
    end
`else
    assign ptr_nx = !owner;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        sel         = ptr;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        bus_address = '0;
        bus_wdata   = '0;
        busy        = (state != IDLE);
        if (req0 && !req1)      sel = 1'b0;
        else if (req1 && !req0) sel = 1'b1;
        case (state)
            IDLE: if (req0 || req1) state_nx = ACCESS;
            ACCESS: begin
                state_nx    = RESP;
                gnt0        = !owner;
                gnt1        = owner;
                bus_address = addr_q;
                bus_wdata   = wdata_q;
                bus_write   = we_q;
                bus_read    = !we_q;
            end
            RESP: begin
                state_nx = IDLE;
                gnt0     = !owner;
                gnt1     = owner;
                ack0     = !owner;
                ack1     = owner;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner   <= 1'b0;
            ptr     <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && (req0 || req1)) begin
                owner   <= sel;
                addr_q  <= sel ? addr1  : addr0;
                wdata_q <= sel ? wdata1 : wdata0;
                we_q    <= sel ? we1    : we0;
            end
            // Peripherals answer combinationally, so the strobe cycle carries the data.
            if (state == ACCESS && !we_q) rdata_q <= bus_rdata;
            if (state == RESP)            ptr     <= ptr_nx;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: directed scenarios plus a randomized
// run checked against a transaction-schedule model of the round-robin bus.
module tb_periph_bus_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int NC = 400;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
`ifdef ARB_LOCK_EN
    logic          lock0 = 1'b0, lock1 = 1'b0;
`endif
    logic          gnt0, gnt1, ack0, ack1, bus_read, bus_write, busy;
    logic [DW-1:0] rdata, bus_wdata, bus_rdata;
    logic [AW-1:0] bus_address;
    logic          fixed_en = 1'b0;
    logic [DW-1:0] fixed_rd = '0;
    logic [6:0]    ctl;
    int            total = 0;
    int            bad = 0;

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] periph(input logic [AW-1:0] a);
        return a ^ 64'h0F0F_5A5A_C3C3_1234;
    endfunction

    assign bus_rdata = fixed_en ? fixed_rd : periph(bus_address);
    assign ctl = {gnt0, gnt1, ack0, ack1, bus_read, bus_write, busy};

    periph_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_read(bus_read), .bus_write(bus_write), .busy(busy)
    );

    task automatic test_reset;
        reset = 1'b1;
        @(posedge clock); @(posedge clock); @(negedge clock);
        total++; if (ctl !== 7'b0) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0); end
        total++; if ({bus_address, bus_wdata, rdata} !== {(AW+2*DW){1'b0}}) begin
            bad++; $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", bus_address, bus_wdata, rdata); end
    endtask

    task automatic test_write;
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 req0 = 1'b1; we0 = 1'b1; addr0 = 64'h1000_0008; wdata0 = 64'hFF;
        @(posedge clock); @(negedge clock);
        total++; if (ctl !== 7'b1000011) begin bad++; $display("FAIL wr_access_ctl: got %b want %b", ctl, 7'b1000011); end
        total++; if (bus_address !== 64'h1000_0008 || bus_wdata !== 64'hFF) begin
            bad++; $display("FAIL wr_bus: addr %h wdata %h want 1000_0008 ff", bus_address, bus_wdata); end
        @(negedge clock);
        total++; if (ctl !== 7'b1010001) begin bad++; $display("FAIL wr_resp_ctl: got %b want %b", ctl, 7'b1010001); end
        req0 = 1'b0;
        @(negedge clock);
        total++; if (ctl !== 7'b0) begin bad++; $display("FAIL wr_idle_ctl: got %b want %b", ctl, 7'b0); end
    endtask

    task automatic test_read;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h1000_0000; fixed_en = 1'b1; fixed_rd = 64'hA5A5;
        @(negedge clock);
        total++; if (ctl !== 7'b0100101 || bus_address !== 64'h1000_0000) begin
            bad++; $display("FAIL rd_access: ctl %b addr %h want 0100101 1000_0000", ctl, bus_address); end
        @(negedge clock);
        total++; if (ctl !== 7'b0101001 || rdata !== 64'hA5A5) begin
            bad++; $display("FAIL rd_resp: ctl %b rdata %h want 0101001 a5a5", ctl, rdata); end
        req1 = 1'b0; fixed_rd = 64'h1234;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            total++; if (ctl !== 7'b0 || rdata !== 64'hA5A5) begin
                bad++; $display("FAIL rd_hold: ctl %b rdata %h want 0 a5a5", ctl, rdata); end
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_alternate;
        logic       o;
        int         ph;
        logic [3:0] e4;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 64'h1000_0010; addr1 = 64'h1000_0020;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            o  = ((i / 3) % 2) == 1;
            ph = i % 3;
            e4 = (ph == 2) ? 4'b0 : {!o, o, (ph == 1) && !o, (ph == 1) && o};
            total++; if ({gnt0, gnt1, ack0, ack1} !== e4) begin
                bad++; $display("FAIL alt_gnt_ack[%0d]: got %b want %b", i, {gnt0, gnt1, ack0, ack1}, e4); end
            if (ph == 1) begin
                total++; if (rdata !== periph(o ? addr1 : addr0)) begin
                    bad++; $display("FAIL alt_rdata[%0d]: got %h want %h", i, rdata, periph(o ? addr1 : addr0)); end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_late_req1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 64'h1000_0004; wdata0 = 64'h3C;
        @(posedge clock); @(negedge clock);
        total++; if (ctl !== 7'b1000011) begin bad++; $display("FAIL late_acc0: got %b want %b", ctl, 7'b1000011); end
        req1 = 1'b1; we1 = 1'b1; addr1 = 64'h1000_000C; wdata1 = 64'hC3;
        @(negedge clock);
        total++; if (ctl !== 7'b1010001) begin bad++; $display("FAIL late_resp0: got %b want %b", ctl, 7'b1010001); end
        req0 = 1'b0;
        @(negedge clock);
        total++; if (ctl !== 7'b0) begin bad++; $display("FAIL late_idle: got %b want %b", ctl, 7'b0); end
        @(negedge clock);
        total++; if (ctl !== 7'b0100011 || bus_address !== 64'h1000_000C || bus_wdata !== 64'hC3) begin
            bad++; $display("FAIL late_acc1: ctl %b addr %h wdata %h want 0100011 1000_000c c3", ctl, bus_address, bus_wdata); end
        @(negedge clock);
        total++; if (ctl !== 7'b0101001) begin bad++; $display("FAIL late_resp1: got %b want %b", ctl, 7'b0101001); end
        req1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        // One requester-0 transaction first so the pointer favours requester 1.
        req0 = 1'b1; we0 = 1'b1; addr0 = 64'h1000_0018; wdata0 = 64'h11;
        @(posedge clock); @(negedge clock); @(negedge clock);
        req0 = 1'b0;
        @(negedge clock);
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b1; addr1 = 64'h1000_0028; wdata1 = 64'h22;
        @(posedge clock); @(negedge clock);
        total++; if (ctl !== 7'b0100011) begin bad++; $display("FAIL rst_pre_acc1: got %b want %b", ctl, 7'b0100011); end
        #1 reset = 1'b1;
        #1;
        total++; if (ctl !== 7'b0 || bus_address !== '0) begin
            bad++; $display("FAIL rst_async_drop: ctl %b addr %h want 0 0", ctl, bus_address); end
        @(posedge clock); @(negedge clock);
        total++; if (ctl !== 7'b0) begin bad++; $display("FAIL rst_no_ack: got %b want %b", ctl, 7'b0); end
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); @(negedge clock);
        total++; if (ctl !== 7'b1000011) begin bad++; $display("FAIL rst_post_gnt0: got %b want %b", ctl, 7'b1000011); end
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_random;
        logic [6:0]    e_ctl  [0:NC+2];
        logic [AW-1:0] e_addr [0:NC+2];
        logic [DW-1:0] e_wd   [0:NC+2];
        logic          e_rdack[0:NC+2];
        logic [DW-1:0] e_rdval[0:NC+2];
        logic [DW-1:0] m_rdata;
        logic          m_ptr, o, w;
        logic [AW-1:0] a;
        int            free_at;
        for (int c = 0; c < NC + 3; c++) begin
            e_ctl[c] = '0; e_addr[c] = '0; e_wd[c] = '0; e_rdack[c] = 1'b0; e_rdval[c] = '0;
        end
        m_rdata = '0; m_ptr = 1'b0; free_at = 0;
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        for (int c = 0; c < NC; c++) begin
            @(negedge clock);
            if (e_rdack[c]) m_rdata = e_rdval[c];
            total++; if (ctl !== e_ctl[c]) begin bad++; $display("FAIL rand_ctl[%0d]: got %b want %b", c, ctl, e_ctl[c]); end
            total++; if (rdata !== m_rdata) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", c, rdata, m_rdata); end
            if (e_ctl[c][1] || e_ctl[c][2]) begin
                total++; if (bus_address !== e_addr[c] || (e_ctl[c][1] && bus_wdata !== e_wd[c])) begin
                    bad++; $display("FAIL rand_bus[%0d]: addr %h wdata %h want %h %h", c, bus_address, bus_wdata, e_addr[c], e_wd[c]); end
            end
            if (req0 && e_ctl[c][4]) req0 = 1'b0;
            if (req1 && e_ctl[c][3]) req1 = 1'b0;
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; we0 = $urandom_range(0, 1) == 1;
                addr0 = 64'h1000_0000 + 64'($urandom_range(0, 255)) * 8; wdata0 = {$urandom, $urandom};
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; we1 = $urandom_range(0, 1) == 1;
                addr1 = 64'h1000_0000 + 64'($urandom_range(0, 255)) * 8; wdata1 = {$urandom, $urandom};
            end
            // A free bus takes a request now: strobe next cycle, ack the one after, free in 3.
            if (c >= free_at && (req0 || req1)) begin
                o = (req0 && req1) ? m_ptr : req1;
                w = o ? we1 : we0;
                a = o ? addr1 : addr0;
                e_ctl[c+1]   = {!o, o, 2'b00, !w, w, 1'b1};
                e_addr[c+1]  = a;
                e_wd[c+1]    = o ? wdata1 : wdata0;
                e_ctl[c+2]   = {!o, o, !o, o, 2'b00, 1'b1};
                e_rdack[c+2] = !w;
                e_rdval[c+2] = periph(a);
                free_at = c + 3;
                m_ptr   = !o;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock); @(negedge clock); @(negedge clock);
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock;
        logic [1:0] e2;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        lock0 = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        @(posedge clock);
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (i % 3 == 0) begin
                e2 = (i / 3 < 4) ? 2'b10 : 2'b01;
                total++; if ({gnt0, gnt1} !== e2) begin
                    bad++; $display("FAIL lock_gnt[%0d]: got %b want %b", i / 3, {gnt0, gnt1}, e2); end
            end
        end
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        @(negedge clock); @(negedge clock);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alternate();
        test_late_req1();
        test_reset_mid();
        test_random();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
